// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address width,
// memory-sequencer state encoding and the instruction used when squashing a stage.
package pipe_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // addi x0,x0,0: what a flushed IF/ID or bubbled ID/EXE register holds.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic reg_hit(input logic en, input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// mem_rd/mem_wr form a level request held by MEM; mem_ready is a one-cycle
// completion pulse, only meaningful while the controller is in ACCESS.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              fwd_en;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_use_src1;
  logic              id_use_src2;
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_rd;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ready;
  logic              branch_taken;
  logic              cnt_clr;
  logic              freeze_pc;
  logic              freeze_if_id;
  logic              flush_if_id;
  logic              bubble_id_exe;
  logic              freeze_back;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  memwait_cnt;
  mem_state_e        dbg_state;

  modport master (
    output fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_dest, exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en,
           mem_rd, mem_wr, mem_ready, branch_taken, cnt_clr,
    input  freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back,
           mem_timeout, stall_cnt, flush_cnt, memwait_cnt, dbg_state
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_dest, exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en,
           mem_rd, mem_wr, mem_ready, branch_taken, cnt_clr,
    output freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back,
           mem_timeout, stall_cnt, flush_cnt, memwait_cnt, dbg_state
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; a synchronous clear beats an increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: RAW hazards in ID, taken branches in EXE and a small
// FSM sequencing multi-cycle MEM accesses, plus saturating event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int            TW         = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic          r_mem_timeout;
  logic          w_mem_req;
  logic          w_mem_freeze;
  logic          w_abort;
  logic          w_exe_hz;
  logic          w_mem_hz;
  logic          w_raw_hz;
  logic          w_flush_ev;
  logic          w_stall_ev;

  // Requests are not honoured while reset is held, so outputs stay quiet then.
  assign w_mem_req = rst && (hz.mem_rd || hz.mem_wr);

  always_comb begin
    w_state_nxt  = r_state;
    w_mem_freeze = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_req) begin
          w_state_nxt  = ST_ACCESS;
          w_mem_freeze = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_mem_freeze = 1'b1;
        if (hz.mem_ready) begin
          w_state_nxt = ST_DONE;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = ST_DONE;
          w_abort     = 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Idle/done keep the timer at zero so each ACCESS starts counting from 0.
      r_timer <= (r_state == ST_ACCESS) ? r_timer + 1'b1 : '0;
      if (hz.cnt_clr) begin
        r_mem_timeout <= 1'b0;
      end else if (w_abort) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign w_exe_hz = reg_hit(hz.id_use_src1 && hz.exe_wb_en, hz.id_src1, hz.exe_dest)
                 || reg_hit(hz.id_use_src2 && hz.exe_wb_en, hz.id_src2, hz.exe_dest);
  assign w_mem_hz = reg_hit(hz.id_use_src1 && hz.mem_wb_en, hz.id_src1, hz.mem_dest)
                 || reg_hit(hz.id_use_src2 && hz.mem_wb_en, hz.id_src2, hz.mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign w_raw_hz = hz.fwd_en ? (hz.exe_mem_rd && w_exe_hz) : (w_exe_hz || w_mem_hz);

  assign w_flush_ev = !w_mem_freeze && hz.branch_taken;
  assign w_stall_ev = !w_mem_freeze && !hz.branch_taken && w_raw_hz;

  assign hz.freeze_pc     = w_mem_freeze || w_stall_ev;
  assign hz.freeze_if_id  = w_mem_freeze || w_stall_ev;
  assign hz.flush_if_id   = w_flush_ev;
  assign hz.bubble_id_exe = w_flush_ev || w_stall_ev;
  assign hz.freeze_back   = w_mem_freeze;
  assign hz.mem_timeout   = r_mem_timeout;
  assign hz.dbg_state     = mem_state_e'(r_state);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_stall_ev), .i_clr(hz.cnt_clr), .o_cnt(hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_flush_ev), .i_clr(hz.cnt_clr), .o_cnt(hz.flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_mem_freeze), .i_clr(hz.cnt_clr), .o_cnt(hz.memwait_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a driver pushes hand-computed per-cycle
// expectations into a queue, and a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CW = 4;
  localparam int W  = 5 + 1 + 3 * CW;

  // {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_FRZ  = 5'b11001;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_RAW  = 5'b11010;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz();

  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {hz.freeze_pc, hz.freeze_if_id, hz.flush_if_id, hz.bubble_id_exe,
               hz.freeze_back, hz.mem_timeout, hz.stall_cnt, hz.flush_cnt, hz.memwait_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got ctrl=%b to=%b stall=%0d flush=%0d memwait=%0d, want ctrl=%b to=%b stall=%0d flush=%0d memwait=%0d",
                 nm, act_v[W-1 -: 5], act_v[3*CW], act_v[3*CW-1 -: CW], act_v[2*CW-1 -: CW],
                 act_v[CW-1:0], exp_v[W-1 -: 5], exp_v[3*CW], exp_v[3*CW-1 -: CW],
                 exp_v[2*CW-1 -: CW], exp_v[CW-1:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] ctrl, input logic to,
                            input logic [CW-1:0] st, input logic [CW-1:0] fl,
                            input logic [CW-1:0] mw);
    exp_q.push_back({ctrl, to, st, fl, mw});
    name_q.push_back(nm);
  endtask

  task automatic idle_in();
    hz.fwd_en       = 1'b0;
    hz.id_src1      = '0;
    hz.id_src2      = '0;
    hz.id_use_src1  = 1'b0;
    hz.id_use_src2  = 1'b0;
    hz.exe_dest     = '0;
    hz.exe_wb_en    = 1'b0;
    hz.exe_mem_rd   = 1'b0;
    hz.mem_dest     = '0;
    hz.mem_wb_en    = 1'b0;
    hz.mem_rd       = 1'b0;
    hz.mem_wr       = 1'b0;
    hz.mem_ready    = 1'b0;
    hz.branch_taken = 1'b0;
    hz.cnt_clr      = 1'b0;
  endtask

  task automatic set_raw(input logic [REG_AW-1:0] r);
    hz.fwd_en      = 1'b0;
    hz.exe_wb_en   = 1'b1;
    hz.exe_dest    = r;
    hz.id_src1     = r;
    hz.id_use_src1 = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst       = 1'b0;
    hz.mem_rd = 1'b1;
    // reset held with a pending load
    repeat (3) begin
      tick();
      expect_out("reset_hold", C_NONE, 1'b0, 0, 0, 0);
    end
    tick(); rst = 1'b1;
    expect_out("release_freeze", C_FRZ, 1'b0, 0, 0, 0);
    tick(); hz.mem_ready = 1'b1;
    expect_out("first_access", C_FRZ, 1'b0, 0, 0, 1);
    tick(); hz.mem_ready = 1'b0;
    expect_out("done_ignores_req", C_NONE, 1'b0, 0, 0, 2);
    tick(); hz.mem_rd = 1'b0; hz.cnt_clr = 1'b1;
    expect_out("clr1", C_NONE, 1'b0, 0, 0, 2);
    tick(); hz.cnt_clr = 1'b0;
    expect_out("clr1_done", C_NONE, 1'b0, 0, 0, 0);

    // load-use and forwarding
    tick();
    hz.fwd_en = 1'b1; hz.exe_mem_rd = 1'b1; hz.exe_wb_en = 1'b1;
    hz.exe_dest = 4'd3; hz.id_src1 = 4'd3; hz.id_use_src1 = 1'b1;
    expect_out("load_use", C_RAW, 1'b0, 0, 0, 0);
    tick(); hz.exe_mem_rd = 1'b0;
    expect_out("fwd_no_load", C_NONE, 1'b0, 1, 0, 0);
    tick(); hz.fwd_en = 1'b0;
    expect_out("nofwd_exe", C_RAW, 1'b0, 1, 0, 0);
    tick(); idle_in();
    hz.fwd_en = 1'b1; hz.mem_wb_en = 1'b1; hz.mem_dest = 4'd5;
    hz.id_src2 = 4'd5; hz.id_use_src2 = 1'b1;
    expect_out("fwd_mem_match", C_NONE, 1'b0, 2, 0, 0);
    tick(); hz.fwd_en = 1'b0;
    expect_out("nofwd_mem", C_RAW, 1'b0, 2, 0, 0);
    tick(); hz.id_use_src2 = 1'b0;
    expect_out("no_use_src2", C_NONE, 1'b0, 3, 0, 0);
    tick(); idle_in();
    hz.exe_dest = 4'd7; hz.id_src1 = 4'd7; hz.id_use_src1 = 1'b1;
    expect_out("no_wb_en", C_NONE, 1'b0, 3, 0, 0);
    tick(); idle_in();
    hz.id_src1 = 4'd4; hz.id_use_src1 = 1'b1; hz.exe_wb_en = 1'b1; hz.exe_dest = 4'd6;
    hz.mem_wb_en = 1'b1; hz.mem_dest = 4'd9;
    expect_out("addr_mismatch", C_NONE, 1'b0, 3, 0, 0);
    tick(); idle_in(); hz.cnt_clr = 1'b1;
    expect_out("clr2", C_NONE, 1'b0, 3, 0, 0);
    tick(); hz.cnt_clr = 1'b0;
    expect_out("clr2_done", C_NONE, 1'b0, 0, 0, 0);

    // store waiting four cycles for memory
    tick(); hz.mem_wr = 1'b1;
    expect_out("mw_idle", C_FRZ, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_out("mw_access", C_FRZ, 1'b0, 0, 0, CW'(k));
    end
    tick(); hz.mem_ready = 1'b1;
    expect_out("mw_ready", C_FRZ, 1'b0, 0, 0, 4);
    tick(); hz.mem_ready = 1'b0;
    expect_out("mw_done", C_NONE, 1'b0, 0, 0, 5);
    tick(); hz.mem_wr = 1'b0; hz.mem_ready = 1'b1;
    expect_out("ready_in_idle", C_NONE, 1'b0, 0, 0, 5);
    tick(); hz.mem_ready = 1'b0;
    expect_out("still_idle", C_NONE, 1'b0, 0, 0, 5);

    // branch vs raw vs memory freeze
    tick(); set_raw(4'd2); hz.branch_taken = 1'b1;
    expect_out("br_over_raw", C_BR, 1'b0, 0, 0, 5);
    tick(); hz.mem_rd = 1'b1;
    expect_out("frz_over_br_idle", C_FRZ, 1'b0, 0, 1, 5);
    tick();
    expect_out("frz_over_br_access", C_FRZ, 1'b0, 0, 1, 6);
    tick(); hz.mem_ready = 1'b1;
    expect_out("frz_access_ready", C_FRZ, 1'b0, 0, 1, 7);
    tick(); hz.mem_ready = 1'b0;
    expect_out("br_in_done", C_BR, 1'b0, 0, 1, 8);
    tick(); hz.mem_rd = 1'b0; hz.branch_taken = 1'b0;
    expect_out("raw_after_br", C_RAW, 1'b0, 0, 2, 8);
    tick(); idle_in();
    expect_out("quiet", C_NONE, 1'b0, 1, 2, 8);
    tick(); hz.cnt_clr = 1'b1;
    expect_out("clr3", C_NONE, 1'b0, 1, 2, 8);
    tick(); hz.cnt_clr = 1'b0;
    expect_out("clr3_done", C_NONE, 1'b0, 0, 0, 0);

    // access abort after 8 cycles in ACCESS
    tick(); hz.mem_rd = 1'b1;
    expect_out("to_idle", C_FRZ, 1'b0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_out("to_access", C_FRZ, 1'b0, 0, 0, CW'(k + 1));
    end
    tick();
    expect_out("to_done", C_NONE, 1'b1, 0, 0, 9);
    tick(); hz.mem_rd = 1'b0;
    expect_out("to_sticky", C_NONE, 1'b1, 0, 0, 9);
    tick();
    expect_out("to_sticky2", C_NONE, 1'b1, 0, 0, 9);
    tick(); hz.cnt_clr = 1'b1;
    expect_out("to_clr", C_NONE, 1'b1, 0, 0, 9);
    tick(); hz.cnt_clr = 1'b0;
    expect_out("to_cleared", C_NONE, 1'b0, 0, 0, 0);

    // stall counter saturation at 15
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) set_raw(4'd1);
      expect_out("stall_sat", C_RAW, 1'b0, (i > 15) ? CW'(15) : CW'(i), 0, 0);
    end
    tick(); idle_in();
    expect_out("sat_hold", C_NONE, 1'b0, 15, 0, 0);

    // reset in the middle of an access
    tick(); hz.mem_rd = 1'b1;
    expect_out("mr_idle", C_FRZ, 1'b0, 15, 0, 0);
    tick();
    expect_out("mr_access", C_FRZ, 1'b0, 15, 0, 1);
    tick(); rst = 1'b0;
    expect_out("mr_in_reset", C_NONE, 1'b0, 0, 0, 0);
    tick(); rst = 1'b1; hz.mem_rd = 1'b0;
    expect_out("mr_released_idle", C_NONE, 1'b0, 0, 0, 0);
    tick();
    expect_out("mr_no_timeout", C_NONE, 1'b0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
